// File: rtl/palette_ctrl_if.sv
// Pixel-lookup and CPU access ports of the palette controller.
// The requester side (pixel pipeline + CPU) is the master; palette_ctrl is the slave.
interface palette_ctrl_if;

  logic       pix_valid;
  logic [4:0] pix_idx;
  logic [5:0] pix_color;
  logic       pix_color_valid;
  logic       pix_drop;

  logic       cpu_req;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;

  modport master (
    output pix_valid,
    output pix_idx,
    input  pix_color,
    input  pix_color_valid,
    input  pix_drop,
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_ack,
    input  cpu_rdata
  );

  modport slave (
    input  pix_valid,
    input  pix_idx,
    output pix_color,
    output pix_color_valid,
    output pix_drop,
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_ack,
    output cpu_rdata
  );

endinterface

// File: rtl/palette_ctrl.sv
// PPU palette sequencer/arbiter: copies the power-on palette from ROM into a 32x6 register
// file, then grants one access per cycle to either the pixel pipeline or the CPU.
module palette_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic [4:0]    rom_addr,
  input  logic [7:0]    rom_dout,
  output logic          init_done,
  palette_ctrl_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic {StInit, StRun} state_e;

  // Mirrors 0x10/0x14/0x18/0x1C onto 0x00/0x04/0x08/0x0C.
  function automatic logic [4:0] map_addr(input logic [4:0] a);
    logic [4:0] m;
    m = a;
    if (a[4] && (a[1:0] == 2'b00)) begin
      m = {1'b0, a[3:0]};
    end
    return m;
  endfunction

  // Pixel lookups additionally collapse every colour-0 slot onto the universal backdrop.
  function automatic logic [4:0] pix_map(input logic [4:0] a);
    logic [4:0] m;
    m = map_addr(a);
    if (a[1:0] == 2'b00) begin
      m = 5'h00;
    end
    return m;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic        init_done_q, init_done_d;
  logic [3:0]  wait_q, wait_d;
  logic [5:0]  pix_color_q, pix_color_d;
  logic        pix_color_valid_q, pix_color_valid_d;
  logic        pix_drop_q, pix_drop_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;

  logic [5:0]  mem [32];

  logic        cpu_elig;
  logic        cpu_grant;
  logic        pix_grant;
  logic        pix_discard;

  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [5:0]  mem_wdata;

  logic        unused_bits;
  assign unused_bits = ^{rom_dout[7:6], bus.cpu_wdata[7:6]};

  // Sequencer and arbiter.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    init_done_d = init_done_q;
    rom_addr    = 5'h00;
    cpu_elig    = 1'b0;
    cpu_grant   = 1'b0;
    pix_grant   = 1'b0;
    pix_discard = 1'b0;

    unique case (state_q)
      StInit: begin
        rom_addr = k_q;
        k_d      = k_q + 5'd1;
        if (k_q == 5'd31) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        // The CPU cannot be re-granted in its own ack cycle: the old request is still up.
        cpu_elig    = bus.cpu_req && !cpu_ack_q;
        cpu_grant   = cpu_elig && (!bus.pix_valid || (wait_q == StarveMax));
        pix_grant   = bus.pix_valid && !cpu_grant;
        pix_discard = bus.pix_valid && cpu_grant;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // Starvation counter: saturates at the limit, which forces the next CPU grant.
  always_comb begin
    wait_d = wait_q;
    if (cpu_grant) begin
      wait_d = 4'd0;
    end else if (cpu_elig && (wait_q != StarveMax)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // Registered responses for both ports.
  always_comb begin
    pix_color_d       = pix_color_q;
    pix_color_valid_d = pix_grant;
    pix_drop_d        = pix_discard;
    cpu_ack_d         = cpu_grant;
    cpu_rdata_d       = cpu_rdata_q;
    if (pix_grant) begin
      pix_color_d = mem[pix_map(bus.pix_idx)];
    end
    if (cpu_grant && !bus.cpu_we) begin
      cpu_rdata_d = {2'b00, mem[map_addr(bus.cpu_addr)]};
    end
  end

  // Register-file write port: ROM copy during init, CPU writes afterwards.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = 5'h00;
    mem_wdata = 6'h00;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = map_addr(k_q);
      mem_wdata = rom_dout[5:0];
    end else if (cpu_grant && bus.cpu_we) begin
      mem_we    = 1'b1;
      mem_waddr = map_addr(bus.cpu_addr);
      mem_wdata = bus.cpu_wdata[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StInit;
      k_q               <= 5'h00;
      init_done_q       <= 1'b0;
      wait_q            <= 4'd0;
      pix_color_q       <= 6'h00;
      pix_color_valid_q <= 1'b0;
      pix_drop_q        <= 1'b0;
      cpu_ack_q         <= 1'b0;
      cpu_rdata_q       <= 8'h00;
    end else begin
      state_q           <= state_d;
      k_q               <= k_d;
      init_done_q       <= init_done_d;
      wait_q            <= wait_d;
      pix_color_q       <= pix_color_d;
      pix_color_valid_q <= pix_color_valid_d;
      pix_drop_q        <= pix_drop_d;
      cpu_ack_q         <= cpu_ack_d;
      cpu_rdata_q       <= cpu_rdata_d;
    end
  end

  // Contents are not reset; init rewrites every live entry.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign init_done           = init_done_q;
  assign bus.pix_color       = pix_color_q;
  assign bus.pix_color_valid = pix_color_valid_q;
  assign bus.pix_drop        = pix_drop_q;
  assign bus.cpu_ack         = cpu_ack_q;
  assign bus.cpu_rdata       = cpu_rdata_q;

endmodule

// File: tb/tb_palette_ctrl.sv
// Self-checking bench for palette_ctrl: ROM model, reference palette model and
// scoreboard queues for pixel and CPU read results.
module tb_palette_ctrl;

  localparam int unsigned SM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rom_addr;
  logic [7:0] rom_dout;
  logic       init_done;

  logic [7:0] rom_tbl [32];
  logic [5:0] model [32];
  logic [7:0] exp_cpu [$];
  logic [5:0] exp_pix [$];

  int total = 0;
  int bad   = 0;

  palette_ctrl_if bus ();

  palette_ctrl #(.STARVE_MAX(SM)) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  assign rom_dout = rom_tbl[rom_addr];

  function automatic logic [4:0] tb_map(input logic [4:0] a);
    return (a inside {5'h10, 5'h14, 5'h18, 5'h1C}) ? a - 5'h10 : a;
  endfunction

  function automatic logic [4:0] tb_pmap(input logic [4:0] a);
    return (a[1:0] == 2'b00) ? 5'h00 : tb_map(a);
  endfunction

  task automatic init_model();
    for (int k = 0; k < 32; k++) model[tb_map(5'(k))] = rom_tbl[k][5:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU transaction; returns in the ack cycle with cpu_req already dropped.
  task automatic cpu_xfer(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                          output int n);
    logic [7:0] e;
    if (!we) exp_cpu.push_back({2'b00, model[tb_map(addr)]});
    else model[tb_map(addr)] = wdata[5:0];
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cpu_ack !== 1'b1 && n < 20);
    total++;
    if (bus.cpu_ack !== 1'b1) begin
      bad++;
      $display("FAIL cpu_ack_timeout addr=%h got_ack=%b want=1", addr, bus.cpu_ack);
      if (!we) void'(exp_cpu.pop_front());
    end else if (!we) begin
      e = exp_cpu.pop_front();
      total++;
      if (bus.cpu_rdata !== e) begin
        bad++;
        $display("FAIL cpu_rdata addr=%h got=%h want=%h", addr, bus.cpu_rdata, e);
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic run_init();
    int  n;
    bit  acked;
    rst = 1'b0; n = 0; acked = 0;
    while (init_done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (bus.cpu_ack === 1'b1) acked = 1;
    end
    total++;
    if (n != 32) begin bad++; $display("FAIL init_length got=%0d want=32", n); end
    total++;
    if (acked) begin bad++; $display("FAIL init_no_ack got=1 want=0"); end
    init_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pix_valid = 1'b0; bus.pix_idx = 5'h00;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 5'h00; bus.cpu_wdata = 8'h00;
    tick(); tick();
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b want=0", init_done); end
    total++; if (bus.pix_color !== 6'h00) begin bad++; $display("FAIL rst_pix_color got=%h want=00", bus.pix_color); end
    total++; if (bus.pix_color_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid got=%b want=0", bus.pix_color_valid); end
    total++; if (bus.pix_drop !== 1'b0) begin bad++; $display("FAIL rst_pix_drop got=%b want=0", bus.pix_drop); end
    total++; if (bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_cpu_ack got=%b want=0", bus.cpu_ack); end
    total++; if (bus.cpu_rdata !== 8'h00) begin bad++; $display("FAIL rst_cpu_rdata got=%h want=00", bus.cpu_rdata); end
    total++; if (rom_addr !== 5'h00) begin bad++; $display("FAIL rst_rom_addr got=%h want=00", rom_addr); end
  endtask

  // CPU read and pixel lookups pending throughout init must be ignored until RUN.
  task automatic test_init();
    logic [5:0] e;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'h01;
    bus.pix_valid = 1'b1; bus.pix_idx = 5'h05;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      total++;
      if (rom_addr !== 5'(i)) begin bad++; $display("FAIL init_rom_addr got=%h want=%h", rom_addr, 5'(i)); end
      total++;
      if (init_done !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.pix_color_valid !== 1'b0) begin
        bad++;
        $display("FAIL init_quiet cycle=%0d got=%b%b%b want=000", i, init_done, bus.cpu_ack,
                 bus.pix_color_valid);
      end
      tick();
    end
    init_model();
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done_rise got=%b want=1", init_done); end
    total++; if (rom_addr !== 5'h00) begin bad++; $display("FAIL run_rom_addr got=%h want=00", rom_addr); end
    total++; if (bus.pix_color_valid !== 1'b0) begin bad++; $display("FAIL init_pix_ignored got=%b want=0", bus.pix_color_valid); end
    for (int c = 0; c < 2; c++) begin
      exp_pix.push_back(model[tb_pmap(5'h05)]);
      tick();
      e = exp_pix.pop_front();
      total++;
      if (bus.pix_color_valid !== 1'b1 || bus.pix_color !== e) begin
        bad++;
        $display("FAIL init_first_pix got=%b/%h want=1/%h", bus.pix_color_valid, bus.pix_color, e);
      end
      total++; if (bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL init_cpu_early got=%b want=0", bus.cpu_ack); end
    end
    bus.pix_valid = 1'b0;
    tick();
    total++; if (bus.cpu_ack !== 1'b1) begin bad++; $display("FAIL init_cpu_ack got=%b want=1", bus.cpu_ack); end
    total++; if (bus.cpu_rdata !== 8'h29) begin bad++; $display("FAIL init_cpu_rdata got=%h want=29", bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    tick();
    total++; if (bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL ack_pulse got=%b want=0", bus.cpu_ack); end
  endtask

  task automatic test_readback();
    int n;
    for (int a = 0; a < 32; a++) begin
      cpu_xfer(1'b0, 5'(a), 8'h00, n);
      tick();
    end
  endtask

  task automatic test_cpu_reads();
    logic [4:0] addrs [3];
    logic [7:0] lits  [3];
    int n;
    addrs = '{5'h05, 5'h1F, 5'h10};
    lits  = '{8'h36, 8'h17, 8'h22};
    for (int i = 0; i < 3; i++) begin
      cpu_xfer(1'b0, addrs[i], 8'h00, n);
      total++; if (n != 1) begin bad++; $display("FAIL cpu_idle_latency got=%0d want=1", n); end
      total++;
      if (bus.cpu_rdata !== lits[i]) begin
        bad++;
        $display("FAIL cpu_read_lit addr=%h got=%h want=%h", addrs[i], bus.cpu_rdata, lits[i]);
      end
      tick();
    end
    test_readback();
  endtask

  task automatic test_pixel();
    logic [4:0] idxs [3];
    logic [5:0] lits [3];
    logic [5:0] e;
    idxs = '{5'h05, 5'h04, 5'h1C};
    lits = '{6'h36, 6'h22, 6'h22};
    for (int i = 0; i < 3; i++) begin
      bus.pix_valid = 1'b1; bus.pix_idx = idxs[i];
      tick();
      bus.pix_valid = 1'b0;
      total++;
      if (bus.pix_color_valid !== 1'b1 || bus.pix_color !== lits[i]) begin
        bad++;
        $display("FAIL pix_lit idx=%h got=%b/%h want=1/%h", idxs[i], bus.pix_color_valid,
                 bus.pix_color, lits[i]);
      end
    end
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.pix_idx = 5'(i);
      exp_pix.push_back(model[tb_pmap(5'(i))]);
      tick();
      e = exp_pix.pop_front();
      total++;
      if (bus.pix_color_valid !== 1'b1 || bus.pix_color !== e) begin
        bad++;
        $display("FAIL pix_stream idx=%h got=%b/%h want=1/%h", 5'(i), bus.pix_color_valid,
                 bus.pix_color, e);
      end
    end
    bus.pix_valid = 1'b0;
    tick();
    total++; if (bus.pix_color_valid !== 1'b0) begin bad++; $display("FAIL pix_idle got=%b want=0", bus.pix_color_valid); end
  endtask

  task automatic pix_check(input logic [4:0] idx, input logic [5:0] lit);
    logic [5:0] e;
    bus.pix_valid = 1'b1; bus.pix_idx = idx;
    exp_pix.push_back(model[tb_pmap(idx)]);
    tick();
    bus.pix_valid = 1'b0;
    e = exp_pix.pop_front();
    total++;
    if (bus.pix_color_valid !== 1'b1 || bus.pix_color !== e || bus.pix_color !== lit) begin
      bad++;
      $display("FAIL pix_after_write idx=%h got=%b/%h want=1/%h", idx, bus.pix_color_valid,
               bus.pix_color, lit);
    end
  endtask

  task automatic test_write_raw();
    int n;
    cpu_xfer(1'b1, 5'h10, 8'hFF, n);
    pix_check(5'h08, 6'h3F);
    cpu_xfer(1'b0, 5'h00, 8'h00, n);
    total++; if (bus.cpu_rdata !== 8'h3F) begin bad++; $display("FAIL raw_cpu_read got=%h want=3f", bus.cpu_rdata); end
    pix_check(5'h08, 6'h3F);
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    cpu_xfer(1'b1, 5'h06, 8'hD5, n);
    cpu_xfer(1'b0, 5'h06, 8'h00, n);
    total++; if (n != 2) begin bad++; $display("FAIL b2b_gap got=%0d want=2", n); end
    total++; if (bus.cpu_rdata !== 8'h15) begin bad++; $display("FAIL b2b_rdata got=%h want=15", bus.cpu_rdata); end
    cpu_xfer(1'b1, 5'h1F, 8'h2A, n);
    total++; if (n != 2) begin bad++; $display("FAIL b2b_gap_wr got=%0d want=2", n); end
    cpu_xfer(1'b0, 5'h1F, 8'h00, n);
    total++; if (bus.cpu_rdata !== 8'h2A) begin bad++; $display("FAIL b2b_rdata2 got=%h want=2a", bus.cpu_rdata); end
    tick();
  endtask

  // Continuous pixel traffic; the CPU read must be forced through after SM losses.
  task automatic test_starve();
    logic       exp_ack;
    logic [5:0] e;
    logic [7:0] ec;
    bus.pix_valid = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'h0D;
    exp_cpu.push_back({2'b00, model[tb_map(5'h0D)]});
    for (int c = 0; c < int'(SM) + 4; c++) begin
      bus.pix_idx = 5'(c + 1);
      if (c != int'(SM)) exp_pix.push_back(model[tb_pmap(5'(c + 1))]);
      tick();
      exp_ack = (c + 1 == int'(SM) + 1);
      total++;
      if (bus.cpu_ack !== exp_ack) begin bad++; $display("FAIL starve_ack cyc=%0d got=%b want=%b", c + 1, bus.cpu_ack, exp_ack); end
      total++;
      if (bus.pix_drop !== exp_ack) begin bad++; $display("FAIL starve_drop cyc=%0d got=%b want=%b", c + 1, bus.pix_drop, exp_ack); end
      total++;
      if (bus.pix_color_valid !== !exp_ack) begin
        bad++;
        $display("FAIL starve_pix_valid cyc=%0d got=%b want=%b", c + 1, bus.pix_color_valid, !exp_ack);
      end
      if (!exp_ack) begin
        e = exp_pix.pop_front();
        total++;
        if (bus.pix_color !== e) begin bad++; $display("FAIL starve_pix cyc=%0d got=%h want=%h", c + 1, bus.pix_color, e); end
      end else begin
        ec = exp_cpu.pop_front();
        total++;
        if (bus.cpu_rdata !== ec) begin bad++; $display("FAIL starve_rdata got=%h want=%h", bus.cpu_rdata, ec); end
        bus.cpu_req = 1'b0;
      end
    end
    bus.pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL mid_rst_init_done got=%b want=0", init_done); end
    total++; if (bus.pix_color !== 6'h00) begin bad++; $display("FAIL mid_rst_pix_color got=%h want=00", bus.pix_color); end
    rst = 1'b0;
    repeat (10) tick();
    total++; if (rom_addr !== 5'd10) begin bad++; $display("FAIL mid_rst_k10 got=%h want=0a", rom_addr); end
    rst = 1'b1;
    tick();
    total++; if (rom_addr !== 5'h00) begin bad++; $display("FAIL mid_rst_k_clear got=%h want=00", rom_addr); end
    run_init();
    // Pending write that loses to pixels, then reset before it can be granted.
    bus.pix_valid = 1'b1; bus.pix_idx = 5'h01;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 5'h03; bus.cpu_wdata = 8'h00;
    tick(); tick();
    rst = 1'b1;
    tick();
    total++; if (bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL pend_rst_ack got=%b want=0", bus.cpu_ack); end
    total++; if (bus.pix_color_valid !== 1'b0) begin bad++; $display("FAIL pend_rst_pix got=%b want=0", bus.pix_color_valid); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL pend_rst_init got=%b want=0", init_done); end
    bus.pix_valid = 1'b0; bus.cpu_req = 1'b0;
    run_init();
    test_readback();
  endtask

  initial begin
    rom_tbl = '{8'h22, 8'h29, 8'h1A, 8'h0F, 8'h22, 8'h36, 8'h17, 8'h0F,
                8'h22, 8'h30, 8'h21, 8'h0F, 8'h22, 8'h27, 8'h17, 8'h0F,
                8'h22, 8'h16, 8'h27, 8'h18, 8'h22, 8'h1A, 8'h30, 8'h27,
                8'h22, 8'h16, 8'h30, 8'h27, 8'h22, 8'h0F, 8'h36, 8'h17};
    test_reset();
    test_init();
    test_cpu_reads();
    test_pixel();
    test_write_raw();
    test_back_to_back();
    test_starve();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
